axis_debug_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that merges the 8-bit AXI-Stream response channels of up to NUM_PORTS axis_debug devices onto the single upstream debug master stream. Debug devices include register maps and other decoder-based peripherals. A grant is held from the first byte of a packet until its tlast beat is accepted, so responses never interleave. Optionally, a stall watchdog aborts a granted packet whose source stops supplying bytes.

---
 rtl/axis_debug_arb_pkg.sv | 19 +
 rtl/axis_debug_rr_pick.sv | 36 +++
 rtl/axis_debug_arbiter.sv | 157 +++++++++++++++
 tb/tb_axis_debug_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_debug_arb_pkg.sv
// Shared types and constants for the axis_debug response-stream arbiter.
// Holds the FSM state encoding, the abort filler byte and the watchdog counter width.
package axis_debug_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam logic [7:0] ABORT_BYTE = 8'hEE;
  localparam int         WD_WIDTH   = 16;

  // Index width that stays legal for a single-port build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_debug_rr_pick.sv
// Combinational round-robin picker: first requester above last_i (wrapping) wins.
// Zero latency; no flow control of its own.
module axis_debug_rr_pick
  import axis_debug_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int IDXW      = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDXW-1:0]      last_i,
  output logic [NUM_PORTS-1:0] pick_o,
  output logic [IDXW-1:0]      pick_idx_o,
  output logic                 any_req_o
);

  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  int cand;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    cand       = 0;
    pick_o     = '0;
    pick_idx_o = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      cand = (int'(last_i) + off) % NUM_PORTS;
      if ((req_i & (ONE << cand)) != '0) begin
        pick_o     = ONE << cand;
        pick_idx_o = IDXW'(cand);
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/axis_debug_arbiter.sv
// Packet-atomic round-robin merge of byte AXI-Stream responses; AXIS_DEBUG_ARB_WATCHDOG_EN adds a stall abort.
// One-cycle arbitration, then combinational pass-through; granted tready follows upstream tready.
module axis_debug_arbiter
  import axis_debug_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_PORTS-1:0]      i_s_axis_tvalid,
  output logic [NUM_PORTS-1:0]      o_s_axis_tready,
  input  logic [NUM_PORTS-1:0][7:0] i_s_axis_tdata,
  input  logic [NUM_PORTS-1:0]      i_s_axis_tlast,
  output logic                      o_m_axis_tvalid,
  input  logic                      i_m_axis_tready,
  output logic [7:0]                o_m_axis_tdata,
  output logic                      o_m_axis_tlast,
  output logic [NUM_PORTS-1:0]      o_grant,
  output logic                      o_timeout
);

  localparam int IDXW = idx_width(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDXW-1:0]      last_q, last_d;

  logic [NUM_PORTS-1:0] pick;
  logic [IDXW-1:0]      pick_idx;
  logic                 any_req;

  logic                 g_vld;
  logic                 g_last;
  logic [7:0]           g_dat;

  axis_debug_rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req_i      (i_s_axis_tvalid),
    .last_i     (last_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx),
    .any_req_o  (any_req)
  );

  assign g_vld  = |(i_s_axis_tvalid & grant_q);
  assign g_last = |(i_s_axis_tlast & grant_q);

  always_comb begin
    g_dat = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) g_dat = g_dat | i_s_axis_tdata[p];
    end
  end

`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WD_WIDTH-1:0] wd_q, wd_d;
  logic                timeout_q, timeout_d;
`endif

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    o_m_axis_tvalid = 1'b0;
    o_m_axis_tdata  = '0;
    o_m_axis_tlast  = 1'b0;
    o_s_axis_tready = '0;
`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
    wd_d            = wd_q;
    timeout_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
        wd_d = '0;
`endif
        if (any_req) begin
          state_d = PASS;
          grant_d = pick;
          last_d  = pick_idx;
        end
      end
      PASS: begin
        o_m_axis_tvalid = g_vld;
        o_m_axis_tdata  = g_dat;
        o_m_axis_tlast  = g_last;
        o_s_axis_tready = grant_q & {NUM_PORTS{i_m_axis_tready}};
        if (g_vld && i_m_axis_tready) begin
`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
          wd_d = '0;
`endif
          if (g_last) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
        // Only a silent source counts as a stall; upstream backpressure does not.
        else if (!g_vld) begin
          if (wd_q == WD_LIMIT) begin
            state_d = ABORT;
            grant_d = '0;
          end else begin
            wd_d = wd_q + WD_WIDTH'(1);
          end
        end
`endif
      end
`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
      ABORT: begin
        o_m_axis_tvalid = 1'b1;
        o_m_axis_tdata  = ABORT_BYTE;
        o_m_axis_tlast  = 1'b1;
        if (i_m_axis_tready) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IDXW'(NUM_PORTS - 1);
`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_grant = grant_q;

`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
  assign o_timeout = timeout_q;
`else
  // Always 0 here; the stall limit only matters when the watchdog is built in.
  assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_axis_debug_arbiter.sv
// Scoreboard bench for axis_debug_arbiter: per-port source queues drive bytes, expected beats queued in order.
`timescale 1ns/1ps
module tb_axis_debug_arbiter;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]      s_vld, s_rdy, s_last;
  logic [NP-1:0][7:0] s_dat;
  logic               m_vld, m_rdy, m_last;
  logic [7:0]         m_dat;
  logic [NP-1:0]      grant;
  logic               tmo;

  axis_debug_arbiter #(
    .NUM_PORTS      (NP),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_s_axis_tvalid (s_vld),
    .o_s_axis_tready (s_rdy),
    .i_s_axis_tdata  (s_dat),
    .i_s_axis_tlast  (s_last),
    .o_m_axis_tvalid (m_vld),
    .i_m_axis_tready (m_rdy),
    .o_m_axis_tdata  (m_dat),
    .o_m_axis_tlast  (m_last),
    .o_grant         (grant),
    .o_timeout       (tmo)
  );

  typedef struct packed {logic bub; logic l; logic [7:0] d;} src_t;
  typedef struct packed {logic [NP-1:0] g; logic l; logic [7:0] d;} exp_t;

  src_t  src_q[NP][$];
  exp_t  exp_q[$];
  logic [NP-1:0] hs;
  logic [NP-1:0] shown_bub;
  bit    tog = 1'b0;
  int    cyc = 0;
  int    nvec = 0;
  int    nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source driver: handshakes sampled mid-cycle, next byte presented just after the edge.
  initial begin
    s_vld = '0; s_dat = '0; s_last = '0; m_rdy = 1'b1; shown_bub = '0; hs = '0;
    forever begin
      @(negedge clk);
      hs = s_vld & s_rdy;
      @(posedge clk);
      #1;
      m_rdy = tog ? ~m_rdy : 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() > 0 && (hs[p] || shown_bub[p])) void'(src_q[p].pop_front());
        shown_bub[p] = 1'b0;
        s_vld[p]     = 1'b0;
        if (src_q[p].size() > 0) begin
          if (src_q[p][0].bub) shown_bub[p] = 1'b1;
          else begin
            s_vld[p]  = 1'b1;
            s_dat[p]  = src_q[p][0].d;
            s_last[p] = src_q[p][0].l;
          end
        end
      end
    end
  end

  task automatic push_byte(input int p, input logic [7:0] d, input logic l);
    src_t s;
    exp_t e;
    s.bub = 1'b0; s.l = l; s.d = d;
    src_q[p].push_back(s);
    e.g = NP'(1) << p; e.l = l; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_bubble(input int p);
    src_t s;
    s.bub = 1'b1; s.l = 1'b0; s.d = 8'h00;
    src_q[p].push_back(s);
  endtask

  task automatic push_pkt(input int p, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) push_byte(p, base + 8'(i), (i == n - 1));
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Waits (bounded) for the next accepted output beat; returns what was seen.
  task automatic next_beat(output bit got, output logic [7:0] d, output logic l,
                           output logic [NP-1:0] g, output int c);
    got = 1'b0; d = '0; l = 1'b0; g = '0; c = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (m_vld && m_rdy) begin
        got = 1'b1; d = m_dat; l = m_last; g = grant; c = cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({grant, tmo, m_vld, m_last, m_dat, s_rdy} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs got=%h want=0", {grant, tmo, m_vld, m_last, m_dat, s_rdy});
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if ({grant, tmo, m_vld, s_rdy} !== '0) begin
      nerr++;
      $display("FAIL idle_after_reset got=%h want=0", {grant, tmo, m_vld, s_rdy});
    end
  endtask

  task automatic test_multi;
    bit got; logic [7:0] d; logic l; logic [NP-1:0] g; int c, prev_c, want; logic prev_l; exp_t e;
    @(posedge clk); #2;
    push_pkt(0, 2, 8'hA0); push_pkt(1, 2, 8'hB0); push_pkt(3, 2, 8'hD0);
    prev_c = 0; prev_l = 1'b0;
    for (int k = 0; k < 6; k++) begin
      next_beat(got, d, l, g, c);
      e = pop_exp();
      nvec++;
      if (!got || {g, l, d} !== e) begin
        nerr++;
        $display("FAIL multi_beat%0d got=%h (seen=%0d) want=%h", k, {g, l, d}, got, e);
      end
      if (k > 0) begin
        want = prev_l ? 2 : 1;
        nvec++;
        if (c - prev_c !== want) begin
          nerr++;
          $display("FAIL multi_gap%0d got=%0d want=%0d", k, c - prev_c, want);
        end
      end
      prev_c = c; prev_l = l;
    end
  endtask

  task automatic test_single;
    bit got; logic [7:0] d; logic l; logic [NP-1:0] g; int c, c0; exp_t e;
    @(posedge clk); #2;
    push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h22, 1'b0); push_byte(2, 8'h33, 1'b1);
    c0 = -1;
    for (int i = 0; i < 20 && c0 < 0; i++) begin
      @(negedge clk);
      if (s_vld[2]) c0 = cyc;
    end
    nvec++;
    if (c0 < 0 || grant !== '0 || m_vld !== 1'b0) begin
      nerr++;
      $display("FAIL single_req_cycle grant=%b m_vld=%b want grant=0 m_vld=0", grant, m_vld);
    end
    for (int k = 0; k < 3; k++) begin
      next_beat(got, d, l, g, c);
      e = pop_exp();
      nvec++;
      if (!got || {g, l, d} !== e || c !== c0 + 1 + k) begin
        nerr++;
        $display("FAIL single_beat%0d got=%h at +%0d want=%h at +%0d", k, {g, l, d}, c - c0, e, 1 + k);
      end
    end
    @(negedge clk);
    nvec++;
    if (grant !== '0 || m_vld !== 1'b0) begin
      nerr++;
      $display("FAIL single_release grant=%b m_vld=%b want 0", grant, m_vld);
    end
  endtask

  task automatic test_stall;
    bit got; logic [7:0] d; logic l; logic [NP-1:0] g; int c, prev_c; exp_t e;
    int gaps[5] = '{0, 1, 6, 1, 2};
    @(posedge clk); #2;
    push_byte(1, 8'h41, 1'b0); push_byte(1, 8'h42, 1'b0);
    repeat (5) push_bubble(1);
    push_byte(1, 8'h43, 1'b0); push_byte(1, 8'h44, 1'b1);
    prev_c = 0;
    for (int k = 0; k < 5; k++) begin
      next_beat(got, d, l, g, c);
      if (k == 0) push_byte(0, 8'h50, 1'b1);
      e = pop_exp();
      nvec++;
      if (!got || {g, l, d} !== e || (k > 0 && c - prev_c !== gaps[k])) begin
        nerr++;
        $display("FAIL stall_beat%0d got=%h gap=%0d want=%h gap=%0d", k, {g, l, d}, c - prev_c, e, gaps[k]);
      end
      prev_c = c;
    end
  endtask

  task automatic test_backpressure;
    int nb; exp_t e;
    @(posedge clk); #2;
    push_byte(3, 8'h31, 1'b0); push_byte(3, 8'h32, 1'b0); push_byte(3, 8'h33, 1'b1);
    tog = 1'b1;
    nb = 0;
    for (int i = 0; i < 40 && nb < 3; i++) begin
      @(negedge clk);
      if (grant === 4'b1000) begin
        nvec++;
        if (s_rdy !== {m_rdy, 3'b000}) begin
          nerr++;
          $display("FAIL bp_tready got=%b want=%b", s_rdy, {m_rdy, 3'b000});
        end
      end
      if (m_vld && m_rdy) begin
        e = pop_exp();
        nvec++;
        if ({grant, m_last, m_dat} !== e) begin
          nerr++;
          $display("FAIL bp_beat%0d got=%h want=%h", nb, {grant, m_last, m_dat}, e);
        end
        nb++;
      end
    end
    tog = 1'b0;
    nvec++;
    if (nb !== 3) begin
      nerr++;
      $display("FAIL bp_count got=%0d want=3", nb);
    end
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if (m_vld !== 1'b0) begin
      nerr++;
      $display("FAIL bp_extra_beat m_vld=%b want 0", m_vld);
    end
  endtask

`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
  task automatic test_watchdog;
    int nb, npulse, c_first, c_abort, c_pulse; exp_t e, ab;
    @(posedge clk); #2;
    push_byte(0, 8'h5A, 1'b0);
    ab.g = '0; ab.l = 1'b1; ab.d = 8'hEE;
    exp_q.push_back(ab);
    push_byte(1, 8'h61, 1'b1);
    repeat (20) push_bubble(0);
    push_byte(0, 8'h5B, 1'b1);
    nb = 0; npulse = 0; c_first = 0; c_abort = 0; c_pulse = 0;
    for (int i = 0; i < 100 && nb < 4; i++) begin
      @(negedge clk);
      if (tmo) begin npulse++; c_pulse = cyc; end
      if (m_vld && m_rdy) begin
        e = pop_exp();
        nvec++;
        if ({grant, m_last, m_dat} !== e) begin
          nerr++;
          $display("FAIL wd_beat%0d got=%h want=%h", nb, {grant, m_last, m_dat}, e);
        end
        if (nb == 0) c_first = cyc;
        if (nb == 1) c_abort = cyc;
        nb++;
      end
    end
    nvec++;
    if (c_abort - c_first !== 9) begin
      nerr++;
      $display("FAIL wd_stall_len got=%0d want=9", c_abort - c_first);
    end
    nvec++;
    if (npulse !== 1 || c_pulse !== c_abort + 1) begin
      nerr++;
      $display("FAIL wd_pulse count=%0d at=+%0d want count=1 at=+1", npulse, c_pulse - c_abort);
    end
  endtask
`endif

  task automatic test_reset_mid;
    bit got; logic [7:0] d; logic l; logic [NP-1:0] g; int c; exp_t e;
    @(posedge clk); #2;
    push_pkt(2, 4, 8'h70);
    for (int k = 0; k < 2; k++) begin
      next_beat(got, d, l, g, c);
      e = pop_exp();
      nvec++;
      if (!got || {g, l, d} !== e) begin
        nerr++;
        $display("FAIL rstmid_beat%0d got=%h want=%h", k, {g, l, d}, e);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    nvec++;
    if ({grant, tmo, m_vld, m_last, m_dat, s_rdy} !== '0) begin
      nerr++;
      $display("FAIL rstmid_outputs got=%h want=0", {grant, tmo, m_vld, m_last, m_dat, s_rdy});
    end
    exp_q.delete();
    for (int p = 0; p < NP; p++) src_q[p].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    push_pkt(0, 1, 8'h80); push_pkt(2, 1, 8'h82); push_pkt(3, 1, 8'h83);
    for (int k = 0; k < 3; k++) begin
      next_beat(got, d, l, g, c);
      e = pop_exp();
      nvec++;
      if (!got || {g, l, d} !== e) begin
        nerr++;
        $display("FAIL rstmid_prio%0d got=%h want=%h", k, {g, l, d}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multi();
    test_single();
    test_stall();
    test_backpressure();
`ifdef AXIS_DEBUG_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
